// File: rtl/mult_wb_arbiter.sv
// rtl/mult_wb_arbiter.sv - writeback arbiter merging ALU and multiply results onto one register-file write port
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef REG_ADDR
`define REG_ADDR 5
`endif

module mult_wb_arbiter #(
   parameter int DATA_W = `REG_SIZE,
   parameter int ADDR_W = `REG_ADDR,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_wr_valid,
   input  logic [ADDR_W-1:0] alu_wr_reg,
   input  logic [DATA_W-1:0] alu_wr_data,
   input  logic              mult_valid,
   input  logic [ADDR_W-1:0] mult_reg,
   input  logic [DATA_W-1:0] mult_data,
   input  logic              mult_overflow,
   output logic              mult_stall,
   input  logic [ADDR_W-1:0] lookup_reg,
   output logic              lookup_hit,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              exc_overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   // parking FIFO storage; live=0 marks an entry whose write was superseded by a younger ALU write
   logic [DEPTH-1:0]  ent_valid_q, ent_valid_d;
   logic [DEPTH-1:0]  ent_live_q,  ent_live_d;
   logic [DEPTH-1:0]  ent_ovf_q,   ent_ovf_d;
   logic [ADDR_W-1:0] ent_dst_q  [DEPTH];
   logic [ADDR_W-1:0] ent_dst_d  [DEPTH];
   logic [DATA_W-1:0] ent_data_q [DEPTH];
   logic [DATA_W-1:0] ent_data_d [DEPTH];

   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   logic              rf_we_q,    rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic              exc_q,      exc_d;

   logic mult_acc;
   logic mult_nz;
   logic alu_nz;
   logic mult_live_in;
   logic fifo_empty;
   logic sel_pop;
   logic sel_byp;
   logic do_push;
   logic hit;

   // stall depends only on the registered count, so there is no input-to-stall path
   assign mult_stall   = (count_q == FULL);
   assign fifo_empty   = (count_q == '0);
   assign mult_acc     = mult_valid && !mult_stall;
   assign mult_nz      = (mult_reg != '0);
   assign alu_nz       = alu_wr_valid && (alu_wr_reg != '0);
   // an ALU write in the same cycle is younger than the incoming multiply result
   assign mult_live_in = !(alu_nz && (alu_wr_reg == mult_reg));

   // ALU has fixed priority; the FIFO head beats a fresh multiply result to keep results in order
   assign sel_pop = !alu_wr_valid && !fifo_empty;
   assign sel_byp = !alu_wr_valid && fifo_empty && mult_acc;
   // r0 results are accepted and dropped, so they never occupy a slot
   assign do_push = mult_acc && mult_nz && !sel_byp;

   // select what reaches the register-file write port next cycle
   always_comb begin
      rf_we_d    = 1'b0;
      exc_d      = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (alu_wr_valid) begin
         rf_we_d    = alu_nz;
         rf_waddr_d = alu_wr_reg;
         rf_wdata_d = alu_wr_data;
      end else if (sel_pop) begin
         rf_we_d    = ent_live_q[rd_ptr_q] && !ent_ovf_q[rd_ptr_q];
         exc_d      = ent_live_q[rd_ptr_q] &&  ent_ovf_q[rd_ptr_q];
         rf_waddr_d = ent_dst_q[rd_ptr_q];
         rf_wdata_d = ent_data_q[rd_ptr_q];
      end else if (sel_byp) begin
         rf_we_d    = mult_nz && !mult_overflow;
         exc_d      = mult_nz &&  mult_overflow;
         rf_waddr_d = mult_reg;
         rf_wdata_d = mult_data;
      end
   end

   // FIFO next state: WAW kill, pop of the head, push of a parked multiply result
   always_comb begin
      ent_valid_d = ent_valid_q;
      ent_live_d  = ent_live_q;
      ent_ovf_d   = ent_ovf_q;
      ent_dst_d   = ent_dst_q;
      ent_data_d  = ent_data_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;

      if (alu_nz) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_q[i] && (ent_dst_q[i] == alu_wr_reg)) begin
               ent_live_d[i] = 1'b0;
            end
         end
      end

      if (sel_pop) begin
         ent_valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d              = rd_ptr_q + PTR_W'(1);
      end

      // a push never lands on the slot being popped: acceptance implies a free slot
      if (do_push) begin
         ent_valid_d[wr_ptr_q] = 1'b1;
         ent_live_d[wr_ptr_q]  = mult_live_in;
         ent_ovf_d[wr_ptr_q]   = mult_overflow;
         ent_dst_d[wr_ptr_q]   = mult_reg;
         ent_data_d[wr_ptr_q]  = mult_data;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end

      case ({do_push, sel_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // pending-write lookup for the hazard unit, covering parked entries and the incoming result
   always_comb begin
      hit = mult_acc && mult_nz && mult_live_in && !mult_overflow && (mult_reg == lookup_reg);
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid_q[i] && ent_live_q[i] && (ent_dst_q[i] == lookup_reg) && (ent_dst_q[i] != '0)) begin
            hit = 1'b1;
         end
      end
   end

   assign lookup_hit = hit;

   // state registers; reset discards every parked result
   always_ff @(posedge clk) begin
      if (reset) begin
         ent_valid_q <= '0;
         ent_live_q  <= '0;
         ent_ovf_q   <= '0;
         ent_dst_q   <= '{default: '0};
         ent_data_q  <= '{default: '0};
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         exc_q       <= 1'b0;
      end else begin
         ent_valid_q <= ent_valid_d;
         ent_live_q  <= ent_live_d;
         ent_ovf_q   <= ent_ovf_d;
         ent_dst_q   <= ent_dst_d;
         ent_data_q  <= ent_data_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         rf_we_q     <= rf_we_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
         exc_q       <= exc_d;
      end
   end

   assign rf_we        = rf_we_q;
   assign rf_waddr     = rf_waddr_q;
   assign rf_wdata     = rf_wdata_q;
   assign exc_overflow = exc_q;

endmodule

// File: tb/tb_mult_wb_arbiter.sv
// tb/tb_mult_wb_arbiter.sv - scoreboard bench for the multiply writeback arbiter
module tb_mult_wb_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          alu_wr_valid;
   logic [AW-1:0] alu_wr_reg;
   logic [DW-1:0] alu_wr_data;
   logic          mult_valid;
   logic [AW-1:0] mult_reg;
   logic [DW-1:0] mult_data;
   logic          mult_overflow;
   logic          mult_stall;
   logic [AW-1:0] lookup_reg;
   logic          lookup_hit;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          exc_overflow;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          exc;
   } wr_t;

   wr_t  alu_q[$];
   wr_t  mult_q[$];
   logic alu_prev = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   mi;

   always #5 clk = ~clk;

   mult_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .alu_wr_valid(alu_wr_valid), .alu_wr_reg(alu_wr_reg), .alu_wr_data(alu_wr_data),
      .mult_valid(mult_valid), .mult_reg(mult_reg), .mult_data(mult_data),
      .mult_overflow(mult_overflow), .mult_stall(mult_stall),
      .lookup_reg(lookup_reg), .lookup_hit(lookup_hit),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .exc_overflow(exc_overflow)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      alu_wr_valid  = 1'b0;
      alu_wr_reg    = '0;
      alu_wr_data   = '0;
      mult_valid    = 1'b0;
      mult_reg      = '0;
      mult_data     = '0;
      mult_overflow = 1'b0;
   endtask

   task automatic set_alu(input logic [AW-1:0] r, input logic [DW-1:0] d);
      alu_wr_valid = 1'b1;
      alu_wr_reg   = r;
      alu_wr_data  = d;
   endtask

   task automatic set_mult(input logic [AW-1:0] r, input logic [DW-1:0] d, input logic ovf);
      mult_valid    = 1'b1;
      mult_reg      = r;
      mult_data     = d;
      mult_overflow = ovf;
   endtask

   // record what this cycle's stimulus must eventually produce
   task automatic sb_update();
      if (reset) begin
         alu_q.delete();
         mult_q.delete();
         alu_prev = 1'b0;
         return;
      end
      if (alu_wr_valid && alu_wr_reg != '0) begin
         for (int i = mult_q.size() - 1; i >= 0; i--) begin
            if (mult_q[i].addr == alu_wr_reg) mult_q.delete(i);
         end
         alu_q.push_back({1'b1, alu_wr_reg, alu_wr_data, 1'b0});
      end
      if (mult_valid && !mult_stall && mult_reg != '0 &&
          !(alu_wr_valid && alu_wr_reg == mult_reg)) begin
         mult_q.push_back({!mult_overflow, mult_reg, mult_data, mult_overflow});
      end
      alu_prev = alu_wr_valid;
   endtask

   // compare the write port against the oldest expected result of the right source
   task automatic monitor();
      wr_t e;
      if (!(rf_we || exc_overflow)) return;
      e = '0;
      if (alu_prev) begin
         if (alu_q.size() > 0) e = alu_q.pop_front();
      end else begin
         if (mult_q.size() > 0) e = mult_q.pop_front();
      end
      check(alu_prev ? "sb_alu_we" : "sb_mult_we", rf_we, e.we);
      check("sb_exc", exc_overflow, e.exc);
      if (e.we) begin
         check("sb_waddr", rf_waddr, e.addr);
         check("sb_wdata", rf_wdata, e.data);
      end
   endtask

   task automatic tick();
      sb_update();
      @(posedge clk);
      @(negedge clk);
      monitor();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      lookup_reg = '0;
      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rst_we", rf_we, 0);
      check("rst_waddr", rf_waddr, 0);
      check("rst_wdata", rf_wdata, 0);
      check("rst_exc", exc_overflow, 0);
      check("rst_stall", mult_stall, 0);
      check("rst_hit", lookup_hit, 0);

      // ALU only
      set_alu(5'd3, 32'h11);
      #1 check("t1_stall", mult_stall, 0);
      tick();
      check("t1_we", rf_we, 1);
      idle();
      check("t1_stall2", mult_stall, 0);
      tick();

      // bypass
      set_mult(5'd5, 32'hABCD, 1'b0);
      lookup_reg = 5'd5;
      #1 check("t2_hit_incoming", lookup_hit, 1);
      tick();
      check("t2_we", rf_we, 1);
      idle();
      #1 check("t2_not_parked", lookup_hit, 0);
      check("t2_stall", mult_stall, 0);
      tick();

      // conflict and drain with upstream holding while stalled
      mi = 1;
      for (int c = 0; c < 14; c++) begin
         logic acc;
         alu_wr_valid = (c < 6);
         alu_wr_reg   = 5'(20 + c);
         alu_wr_data  = 32'h100 + 32'(c);
         mult_valid   = (mi <= 6);
         mult_reg     = 5'(mi);
         mult_data    = 32'h1000 + 32'(mi);
         #1;
         check($sformatf("t3_stall_c%0d", c), mult_stall, (c >= 4 && c <= 6));
         acc = mult_valid && !mult_stall;
         tick();
         if (acc) mi++;
         if (c >= 6 && c <= 11) begin
            check($sformatf("t3_drain_we_c%0d", c), rf_we, 1);
            check($sformatf("t3_drain_addr_c%0d", c), rf_waddr, 64'(c - 5));
         end
      end
      check("t3_all_accepted", mi, 7);
      idle();

      // WAW kill of a parked entry
      set_alu(5'd10, 32'h33);
      set_mult(5'd7, 32'h1, 1'b0);
      tick();
      idle();
      set_alu(5'd7, 32'h2);
      lookup_reg = 5'd7;
      #1 check("t4_hit_before", lookup_hit, 1);
      tick();
      set_alu(5'd11, 32'h44);
      #1 check("t4_hit_after", lookup_hit, 0);
      tick();
      idle();
      tick();
      check("t4_killed_we", rf_we, 0);
      check("t4_killed_exc", exc_overflow, 0);

      // WAW kill of a result accepted in the same cycle
      set_alu(5'd8, 32'h9);
      set_mult(5'd8, 32'h7, 1'b0);
      lookup_reg = 5'd8;
      #1 check("t4b_hit_incoming", lookup_hit, 0);
      tick();
      idle();
      #1 check("t4b_hit_parked", lookup_hit, 0);
      tick();
      check("t4b_killed_we", rf_we, 0);

      // overflow bypass then r0
      set_mult(5'd9, 32'hDEAD, 1'b1);
      lookup_reg = 5'd9;
      #1 check("t5_hit_ovf", lookup_hit, 0);
      tick();
      check("t5_ovf_we", rf_we, 0);
      check("t5_ovf_exc", exc_overflow, 1);
      idle();
      set_mult(5'd0, 32'h5, 1'b0);
      lookup_reg = 5'd0;
      #1 check("t5_hit_r0", lookup_hit, 0);
      tick();
      check("t5_r0_we", rf_we, 0);
      check("t5_r0_exc", exc_overflow, 0);
      idle();
      set_alu(5'd0, 32'h55);
      tick();
      check("t5_alu_r0_we", rf_we, 0);

      // overflow on a parked entry
      set_alu(5'd13, 32'h77);
      set_mult(5'd12, 32'hBEEF, 1'b1);
      tick();
      idle();
      tick();
      check("t5q_we", rf_we, 0);
      check("t5q_exc", exc_overflow, 1);

      // reset with three parked entries
      for (int i = 0; i < 3; i++) begin
         set_alu(5'(20 + i), 32'h200 + 32'(i));
         set_mult(5'(14 + i), 32'h300 + 32'(i), 1'b0);
         tick();
      end
      idle();
      reset = 1'b1;
      lookup_reg = 5'd14;
      #1 check("t6_hit_parked", lookup_hit, 1);
      tick();
      reset = 1'b0;
      #1 check("t6_stall", mult_stall, 0);
      check("t6_hit_cleared", lookup_hit, 0);
      tick();
      check("t6_we_1", rf_we, 0);
      tick();
      check("t6_we_2", rf_we, 0);
      check("t6_exc_2", exc_overflow, 0);

      check("alu_q_left", alu_q.size(), 0);
      check("mult_q_left", mult_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mult_wb_arbiter.md
# mult_wb_arbiter

Writeback arbiter that sits after the final multiply stage and in front of the register file's single write port. It merges the in-order main-pipe (ALU) writeback with multiply results and gives the ALU path fixed priority. Multiply results that lose arbitration are parked in a small in-order FIFO. When that FIFO fills, the arbiter back-pressures the multiply pipeline. It also exposes a pending-write lookup so the hazard unit can hold dependent readers.

## Interface
Parameters:
- DATA_W, default `REG_SIZE (32): result width
- ADDR_W, default `REG_ADDR (5): register address width
- DEPTH, default 4: parking FIFO entries, power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock, sampled on posedge clk
- alu_wr_valid  in  1  main-pipe writeback request
- alu_wr_reg  in  ADDR_W  main-pipe destination register
- alu_wr_data  in  DATA_W  main-pipe write data
- mult_valid  in  1  multiply result valid (regwrite from last multiply stage)
- mult_reg  in  ADDR_W  multiply destination register
- mult_data  in  DATA_W  multiply result
- mult_overflow  in  1  multiply overflow flag
- mult_stall  out  1  high = multiply pipe must hold (drive its stage we low)
- lookup_reg  in  ADDR_W  register queried by hazard unit
- lookup_hit  out  1  a pending multiply write targets lookup_reg
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- exc_overflow  out  1  one-cycle pulse: a multiply result retired with overflow

## Operation
- Accept: a multiply result is accepted when mult_valid && !mult_stall. While stalled, the upstream holds mult_* stable.
- mult_stall = (count == DEPTH). Combinational from registered count only; no input-to-output path.
- Register 0: an ALU or multiply request with destination 0 is accepted, never written, never queued, and never produces lookup_hit.
- Per-cycle selection, in priority order:
  1. alu_wr_valid: write the ALU request.
  2. Else FIFO non-empty: pop the head.
  3. Else an accepted multiply result: bypass it straight to the write port.
- An accepted multiply result not consumed by selection (3) is pushed. Push and pop may occur in the same cycle; count is then unchanged.
- WAW kill: an ALU write to register R (R≠0) clears the write-enable of every FIFO entry with dst R. It also clears the write-enable of a multiply result accepted in the same cycle with dst R; that result is still pushed, as a killed entry. The ALU write is always treated as the youngest.
- Killed entries still occupy slots and pop in order. When popped they produce rf_we=0 and no exc_overflow.
- Overflow: a live multiply entry with overflow=1 that is selected produces rf_we=0 and exc_overflow=1 the next cycle. The destination register is not written.
- lookup_hit = OR over FIFO entries that are valid, live, have dst==lookup_reg, and dst≠0. It also includes an accepted, live, non-overflow incoming multiply result with mult_reg==lookup_reg. Combinational.
- FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Reset: count=0, all entries invalid, rf_we=0, rf_waddr=0, rf_wdata=0, exc_overflow=0, hence mult_stall=0 and lookup_hit=0. Reset mid-operation discards all queued results; nothing is written the following cycle.

## Timing
- Selection in cycle N appears on rf_we/rf_waddr/rf_wdata/exc_overflow in cycle N+1.
- ALU latency: 1 cycle. Multiply bypass latency: 1 cycle. Queued multiply latency: 1 cycle after the first cycle with no ALU write and the entry at the head.
- mult_stall rises in the cycle after the push that makes count==DEPTH. It falls in the cycle after the first pop, provided no push occurs in that same cycle.
- When count==DEPTH there is no acceptance, so a pop lowers count to DEPTH-1.
- Throughput: one register-file write per cycle maximum. Multiply results drain only in ALU-idle cycles.

## Test plan
- ALU only: alu (R3, 0x11) → next cycle rf_we=1, rf_waddr=3, rf_wdata=0x11. mult_stall=0 throughout.
- Bypass: mult (R5, 0xABCD), ALU idle, FIFO empty → next cycle write R5=0xABCD. count stays 0.
- Conflict and drain: ALU valid for 6 consecutive cycles while mult_valid is held with R1..R6 →
  - count reaches 4 and mult_stall=1 from cycle 5;
  - R5 and R6 are held upstream;
  - after the ALU goes idle, writes R1, R2, R3, R4, R5, R6 occur in order on consecutive cycles.
- WAW kill: queue mult R7=0x1. Then ALU writes R7=0x2 with the ALU busy → lookup_reg=7 gives lookup_hit=0 after the kill. The queued entry pops with rf_we=0; R7 is written only once, with 0x2.
- Overflow and r0: mult (R9, overflow=1) then mult (R0, 0x5) → first cycle: rf_we=0, exc_overflow=1. Second cycle: rf_we=0, exc_overflow=0.
- Reset mid-queue: 3 queued entries, assert reset for 1 cycle → count=0, mult_stall=0, rf_we=0 for the following 2 cycles with no inputs.
